// File: rtl/mem_ctrl_if.sv
// rtl/mem_ctrl_if.sv - request, response and RAM signals of the byte-wide memory controller.
interface mem_ctrl_if;
  logic        fet_mem_enable;
  logic [31:0] fet_pc;
  logic        lsb_mem_enable;
  logic        lsb_mem_wr;
  logic [1:0]  lsb_mem_len;
  logic        lsb_mem_signed;
  logic [31:0] lsb_mem_addr;
  logic [31:0] lsb_mem_data;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        mem_inst_ready;
  logic [31:0] mem_inst;
  logic [31:0] mem_inst_addr;
  logic        mem_data_ready;
  logic [31:0] mem_data;

  modport slave (
    input  fet_mem_enable, fet_pc, lsb_mem_enable, lsb_mem_wr, lsb_mem_len,
           lsb_mem_signed, lsb_mem_addr, lsb_mem_data, mem_din,
    output mem_dout, mem_a, mem_wr, mem_inst_ready, mem_inst, mem_inst_addr,
           mem_data_ready, mem_data
  );

  modport master (
    output fet_mem_enable, fet_pc, lsb_mem_enable, lsb_mem_wr, lsb_mem_len,
           lsb_mem_signed, lsb_mem_addr, lsb_mem_data, mem_din,
    input  mem_dout, mem_a, mem_wr, mem_inst_ready, mem_inst, mem_inst_addr,
           mem_data_ready, mem_data
  );
endinterface

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - single-port byte RAM controller arbitrating icache refills and LSB loads/stores.
module mem_ctrl #(
  parameter logic [31:0] IO_BASE     = 32'h00030000,
  parameter int unsigned FETCH_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       flush,
  input  logic       io_buffer_full,
  mem_ctrl_if.slave  bus
);

  localparam logic [1:0] IO_SEL  = IO_BASE[17:16];
  localparam logic [2:0] FETCH_N = 3'(FETCH_BYTES);

  typedef enum logic [1:0] {IDLE, IFETCH, LOAD, STORE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] base_q, base_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  len_q, len_d;
  logic        sgn_q, sgn_d;
  logic [31:0] buf_q, buf_d;
  logic        pend_q, pend_d;
  logic        hold_q, hold_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        irdy_q, irdy_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] iaddr_q, iaddr_d;
  logic        drdy_q, drdy_d;
  logic [31:0] dres_q, dres_d;
  logic        written;
  logic [2:0]  k;

  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      2'd0:    len_bytes = 3'd1;
      2'd1:    len_bytes = 3'd2;
      default: len_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] len, input logic sgn);
    case (len)
      2'd0:    extend = {{24{sgn & w[7]}}, w[7:0]};
      2'd1:    extend = {{16{sgn & w[15]}}, w[15:0]};
      default: extend = w;
    endcase
  endfunction

  // Counter value c means the byte arriving on mem_din now belongs to slot c-1.
  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [2:0] c, input logic [7:0] b);
    put_byte = w;
    case (c)
      3'd1:    put_byte[7:0]   = b;
      3'd2:    put_byte[15:8]  = b;
      3'd3:    put_byte[23:16] = b;
      3'd4:    put_byte[31:24] = b;
      default: put_byte = w;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    base_d     = base_q;
    data_d     = data_q;
    len_d      = len_q;
    sgn_d      = sgn_q;
    buf_d      = buf_q;
    pend_d     = 1'b0;
    hold_d     = 1'b0;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = 1'b0;
    irdy_d     = 1'b0;
    inst_d     = inst_q;
    iaddr_d    = iaddr_q;
    drdy_d     = 1'b0;
    dres_d     = dres_q;
    written    = mem_wr_q | pend_q;
    k          = written ? cnt_q + 3'd1 : cnt_q;

    if (!rdy) begin
      // Frozen: remember a write that already hit the RAM and grab the read byte
      // in flight, since mem_din stops tracking the counter while mem_a is held.
      irdy_d = irdy_q;
      drdy_d = drdy_q;
      pend_d = pend_q | mem_wr_q;
      hold_d = 1'b1;
      if (!hold_q && (state_q == IFETCH || state_q == LOAD))
        buf_d = put_byte(buf_q, cnt_q, bus.mem_din);
    end else begin
      case (state_q)
        IDLE: begin
          if (!(irdy_q || drdy_q)) begin
            if (bus.lsb_mem_enable) begin
              base_d  = bus.lsb_mem_addr;
              len_d   = bus.lsb_mem_len;
              sgn_d   = bus.lsb_mem_signed;
              data_d  = bus.lsb_mem_data;
              n_d     = len_bytes(bus.lsb_mem_len);
              cnt_d   = 3'd0;
              buf_d   = 32'd0;
              mem_a_d = bus.lsb_mem_addr;
              if (bus.lsb_mem_wr) begin
                state_d    = STORE;
                mem_dout_d = bus.lsb_mem_data[7:0];
                mem_wr_d   = !((bus.lsb_mem_addr[17:16] == IO_SEL) && io_buffer_full);
              end else begin
                state_d = LOAD;
              end
            end else if (bus.fet_mem_enable) begin
              base_d  = bus.fet_pc;
              n_d     = FETCH_N;
              cnt_d   = 3'd0;
              buf_d   = 32'd0;
              mem_a_d = bus.fet_pc;
              state_d = IFETCH;
            end
          end
        end
        IFETCH, LOAD: begin
          if (flush) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q + 3'd1 < n_q)
              mem_a_d = base_q + 32'(cnt_q + 3'd1);
            if (!hold_q)
              buf_d = put_byte(buf_q, cnt_q, bus.mem_din);
            if (cnt_q == n_q) begin
              state_d = IDLE;
              cnt_d   = 3'd0;
              if (state_q == IFETCH) begin
                irdy_d  = 1'b1;
                inst_d  = buf_d;
                iaddr_d = base_q;
              end else begin
                drdy_d = 1'b1;
                dres_d = extend(buf_d, len_q, sgn_q);
              end
            end
          end
        end
        STORE: begin
          if (written && (cnt_q + 3'd1 == n_q)) begin
            state_d = IDLE;
            cnt_d   = 3'd0;
            drdy_d  = 1'b1;
            dres_d  = 32'd0;
          end else begin
            cnt_d      = k;
            mem_a_d    = base_q + 32'(k);
            mem_dout_d = 8'(data_q >> {k[1:0], 3'b000});
            mem_wr_d   = !((base_q[17:16] == IO_SEL) && io_buffer_full);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      n_q        <= 3'd0;
      base_q     <= 32'd0;
      data_q     <= 32'd0;
      len_q      <= 2'd0;
      sgn_q      <= 1'b0;
      buf_q      <= 32'd0;
      pend_q     <= 1'b0;
      hold_q     <= 1'b0;
      mem_a_q    <= 32'd0;
      mem_dout_q <= 8'd0;
      mem_wr_q   <= 1'b0;
      irdy_q     <= 1'b0;
      inst_q     <= 32'd0;
      iaddr_q    <= 32'd0;
      drdy_q     <= 1'b0;
      dres_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      base_q     <= base_d;
      data_q     <= data_d;
      len_q      <= len_d;
      sgn_q      <= sgn_d;
      buf_q      <= buf_d;
      pend_q     <= pend_d;
      hold_q     <= hold_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      irdy_q     <= irdy_d;
      inst_q     <= inst_d;
      iaddr_q    <= iaddr_d;
      drdy_q     <= drdy_d;
      dres_q     <= dres_d;
    end
  end

  assign bus.mem_a          = mem_a_q;
  assign bus.mem_dout       = mem_dout_q;
  assign bus.mem_wr         = mem_wr_q;
  assign bus.mem_inst_ready = irdy_q;
  assign bus.mem_inst       = inst_q;
  assign bus.mem_inst_addr  = iaddr_q;
  assign bus.mem_data_ready = drdy_q;
  assign bus.mem_data       = dres_q;

endmodule
